// File: rtl/game_tick_pkg.sv
// Shared types and constants for the game-tick sequencer: phase states,
// LFSR feedback mask and enemy step direction encodings.
package game_tick_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENEMY,
    ST_BULLET,
    ST_COLLIDE,
    ST_RENDER
  } state_t;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // DIR_DOWN moves the enemy to row+1, DIR_UP to row-1.
  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  // One step of a 16-bit right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return cur[0] ? ((cur >> 1) ^ LFSR_MASK) : (cur >> 1);
  endfunction

endpackage

// File: rtl/game_tick_sequencer_prescaler.sv
// Clock-enable prescaler: emits a one-cycle tick every TICK_DIV clocks,
// frozen (no count, no tick) while pause_i is high.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 12500000
) (
  input  logic clk,
  input  logic rst,
  input  logic pause_i,
  output logic tick_o
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = !pause_i && (cnt_q == LAST);

  always_comb begin
    // NOTE: next-state gets a default before any branch so no latch is inferred.
    cnt_d = cnt_q;
    if (!pause_i) cnt_d = tick_o ? '0 : cnt_q + CW'(1);
  end

  // NOTE: state registers use non-blocking assignments; reset is synchronous
  // and active-low, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/game_tick_sequencer.sv
// Game-tick sequencer: ENEMY -> BULLET -> COLLIDE -> RENDER per tick via
// req/done handshakes. Optional per-phase watchdog: GAME_TICK_SEQ_WATCHDOG_EN.
module game_tick_sequencer
  import game_tick_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 12500000,
  parameter int unsigned ROW_MIN     = 1,
  parameter int unsigned ROW_MAX     = 6,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          WDOG_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause,
  input  logic [2:0]  enemy_row,
  output logic        enemy_step_req,
  output logic        enemy_step_dir,
  input  logic        enemy_step_done,
  output logic        bullet_step_req,
  input  logic        bullet_step_done,
  output logic        collide_req,
  input  logic        collide_done,
  input  logic        collide_hit,
  output logic        frame_req,
  input  logic        frame_done,
  output logic        hit,
  output logic [7:0]  score,
  output logic [15:0] tick_cnt,
  output logic        busy,
  output logic        overrun,
  output logic        fault
);

  localparam logic [15:0] SEED   = (LFSR_SEED == 16'h0) ? 16'h1 : LFSR_SEED;
  localparam logic [2:0]  ROW_LO = 3'(ROW_MIN);
  localparam logic [2:0]  ROW_HI = 3'(ROW_MAX);

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        dir_q, dir_d;
  logic        hit_q, hit_d;
  logic [7:0]  score_q, score_d;
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic        overrun_q, overrun_d;
  logic        tick, phase_done, wdog_expire, advance;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .pause_i (pause),
    .tick_o  (tick)
  );

  always_comb begin
    phase_done = 1'b0;
    case (state_q)
      ST_ENEMY:   phase_done = enemy_step_done;
      ST_BULLET:  phase_done = bullet_step_done;
      ST_COLLIDE: phase_done = collide_done;
      ST_RENDER:  phase_done = frame_done;
      default:    phase_done = 1'b0;
    endcase
  end

  assign advance = phase_done || wdog_expire;

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    dir_d      = dir_q;
    hit_d      = 1'b0;
    score_d    = score_q;
    tick_cnt_d = tick_cnt_q;
    overrun_d  = overrun_q || (tick && state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: if (tick) begin
        lfsr_d  = lfsr_next(lfsr_q);
        dir_d   = lfsr_d[0];
        // Bounds win over the random pick so the enemy never leaves its band.
        if (enemy_row >= ROW_HI)      dir_d = DIR_UP;
        else if (enemy_row <= ROW_LO) dir_d = DIR_DOWN;
        state_d = ST_ENEMY;
      end
      ST_ENEMY:  if (advance) state_d = ST_BULLET;
      ST_BULLET: if (advance) state_d = ST_COLLIDE;
      ST_COLLIDE: if (advance) begin
        state_d = ST_RENDER;
        if (collide_done && collide_hit) begin
          hit_d = 1'b1;
          if (score_q != 8'hFF) score_d = score_q + 8'd1;
        end
      end
      ST_RENDER: if (advance) begin
        state_d    = ST_IDLE;
        tick_cnt_d = tick_cnt_q + 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= SEED;
      dir_q      <= DIR_DOWN;
      hit_q      <= 1'b0;
      score_q    <= '0;
      tick_cnt_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      dir_q      <= dir_d;
      hit_q      <= hit_d;
      score_q    <= score_d;
      tick_cnt_q <= tick_cnt_d;
      overrun_q  <= overrun_d;
    end
  end

`ifdef GAME_TICK_SEQ_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);

  logic [WW-1:0] wdog_q, wdog_d;
  logic          fault_q, fault_d;

  // Expires on the last allowed cycle of a phase so the phase lasts exactly WDOG_CYCLES.
  assign wdog_expire = (state_q != ST_IDLE) && !phase_done && (wdog_q == WW'(WDOG_CYCLES - 1));

  always_comb begin
    wdog_d  = (state_q == ST_IDLE || state_d != state_q) ? '0 : wdog_q + WW'(1);
    fault_d = fault_q || wdog_expire;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wdog_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  assign wdog_expire = 1'b0;
  // Phases wait forever; the watchdog limit only keeps the parameter list uniform.
  assign fault       = (WDOG_CYCLES < 0);
`endif

  assign enemy_step_req  = (state_q == ST_ENEMY);
  assign bullet_step_req = (state_q == ST_BULLET);
  assign collide_req     = (state_q == ST_COLLIDE);
  assign frame_req       = (state_q == ST_RENDER);
  assign enemy_step_dir  = dir_q;
  assign hit             = hit_q;
  assign score           = score_q;
  assign tick_cnt        = tick_cnt_q;
  assign busy            = (state_q != ST_IDLE);
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_game_tick_sequencer.sv
// Scoreboard bench for game_tick_sequencer: stimulus pushes expected dir,
// tick_cnt and score values; a monitor pops and compares on DUT events.
module tb_game_tick_sequencer;

  localparam int TICK_DIV = 8;
  localparam int WDOG     = 4;
  localparam int PAUSE_CY = 50;

  logic        clk = 1'b0, rst = 1'b0, pause = 1'b0;
  logic [2:0]  enemy_row = 3'd3;
  logic        en_done = 1'b1, bu_done = 1'b1, co_done = 1'b1, co_hit = 1'b0, fr_done = 1'b1;
  logic        enemy_step_req, enemy_step_dir, bullet_step_req, collide_req, frame_req;
  logic        hit, busy, overrun, fault;
  logic [7:0]  score;
  logic [15:0] tick_cnt;
  logic [3:0]  reqs;

  int          n_vec = 0, n_miss = 0, cyc = 0, last_rise = 0, hits_seen = 0, exp_score = 0;
  logic [15:0] exp_tick = '0;
  bit          dir_exp_q[$];
  logic [15:0] tick_exp_q[$];
  logic [7:0]  score_exp_q[$];

  game_tick_sequencer #(
    .TICK_DIV(TICK_DIV), .ROW_MIN(1), .ROW_MAX(6), .LFSR_SEED(16'hACE1), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk(clk), .rst(rst), .pause(pause), .enemy_row(enemy_row),
    .enemy_step_req(enemy_step_req), .enemy_step_dir(enemy_step_dir), .enemy_step_done(en_done),
    .bullet_step_req(bullet_step_req), .bullet_step_done(bu_done),
    .collide_req(collide_req), .collide_done(co_done), .collide_hit(co_hit),
    .frame_req(frame_req), .frame_done(fr_done),
    .hit(hit), .score(score), .tick_cnt(tick_cnt), .busy(busy), .overrun(overrun), .fault(fault)
  );

  assign reqs = {enemy_step_req, bullet_step_req, collide_req, frame_req};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_req();
    int i = 0;
    while (!enemy_step_req && i < 100) begin @(negedge clk); i++; end
    check("req_rise_timeout", enemy_step_req, 1'b1);
    last_rise = cyc;
  endtask

  task automatic wait_idle();
    int i = 0;
    while (busy && i < 100) begin @(negedge clk); i++; end
    check("idle_timeout", busy, 1'b0);
  endtask

  task automatic expect_seq(input bit chk_dir, input bit exp_dir, input bit exp_hit);
    if (chk_dir) dir_exp_q.push_back(exp_dir);
    exp_tick = exp_tick + 16'd1;
    tick_exp_q.push_back(exp_tick);
    if (exp_hit) begin
      if (exp_score < 255) exp_score++;
      score_exp_q.push_back(8'(exp_score));
    end
  endtask

  // One full sequence, called from IDLE; optionally checks the T+1..T+5 phase walk.
  task automatic run_seq(input logic [2:0] row, input bit chk_dir, input bit exp_dir,
                         input bit walk, input bit exp_hit);
    enemy_row = row;
    expect_seq(chk_dir, exp_dir, exp_hit);
    wait_req();
    if (walk) begin
      for (int p = 0; p < 4; p++) begin
        check("req_walk", reqs, 4'b1000 >> p);
        @(negedge clk);
      end
      check("busy_low_T+5", busy, 1'b0);
    end
    wait_idle();
  endtask

  initial begin : monitor
    logic        prev_req;
    logic [15:0] prev_tick;
    prev_req  = 1'b0;
    prev_tick = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_req  = 1'b0;
        prev_tick = tick_cnt;
      end else begin
        if (enemy_step_req && !prev_req && dir_exp_q.size() > 0)
          check("enemy_step_dir", enemy_step_dir, dir_exp_q.pop_front());
        if (tick_cnt != prev_tick) begin
          if (tick_exp_q.size() > 0) check("tick_cnt", tick_cnt, tick_exp_q.pop_front());
          else                       check("tick_cnt_unexpected", tick_cnt, prev_tick);
        end
        if (hit) begin
          hits_seen++;
          if (score_exp_q.size() > 0) check("score", score, score_exp_q.pop_front());
          else                        check("hit_unexpected", hit, 1'b0);
        end
        prev_req  = enemy_step_req;
        prev_tick = tick_cnt;
      end
    end
  end

  initial begin : stimulus
    // Rows and expected dirs for the first 8 ticks; LFSR bit0 from seed ACE1 is 0,0,0,0,1,1,1,0.
    logic [2:0] rows [8] = '{3'd6, 3'd3, 3'd3, 3'd3, 3'd1, 3'd3, 3'd0, 3'd7};
    bit         dirs [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int         prev_rise;
    logic       busy_seen;

    repeat (3) @(negedge clk);
    check("rst_reqs", reqs, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_dir", enemy_step_dir, 1'b0);
    check("rst_hit", hit, 1'b0);
    check("rst_score", score, 8'd0);
    check("rst_tick_cnt", tick_cnt, 16'd0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_fault", fault, 1'b0);
    rst = 1'b1;

    for (int k = 0; k < 8; k++) begin
      prev_rise = last_rise;
      run_seq(rows[k], 1'b1, dirs[k], 1'b1, 1'b0);
      if (k > 0) check("tick_period", last_rise - prev_rise, TICK_DIV);
    end
    check("overrun_clean", overrun, 1'b0);
    check("tick_cnt_after_8", tick_cnt, 16'd8);

    // Prescaler reads 4 here; frozen for PAUSE_CY cycles it still owes 4 cycles to the tick.
    prev_rise = last_rise;
    pause     = 1'b1;
    busy_seen = 1'b0;
    repeat (PAUSE_CY) begin
      @(negedge clk);
      busy_seen |= busy;
    end
    pause = 1'b0;
    check("pause_no_tick", busy_seen, 1'b0);
    run_seq(3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pause_resume_tick", last_rise - prev_rise, TICK_DIV + PAUSE_CY);

`ifndef GAME_TICK_SEQ_WATCHDOG_EN
    bu_done   = 1'b0;
    enemy_row = 3'd3;
    expect_seq(1'b0, 1'b0, 1'b0);
    wait_req();
    @(negedge clk);
    repeat (20) @(negedge clk);
    check("stall_overrun", overrun, 1'b1);
    check("stall_bullet_req", bullet_step_req, 1'b1);
    bu_done = 1'b1;
    wait_idle();
    run_seq(3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    check("overrun_sticky", overrun, 1'b1);
`endif

    co_hit = 1'b1;
    for (int k = 0; k < 300; k++) run_seq(3'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    co_hit = 1'b0;
    check("score_saturated", score, 8'd255);
    check("hit_pulses", hits_seen, 300);
    check("tick_cnt_total", tick_cnt, exp_tick);

`ifdef GAME_TICK_SEQ_WATCHDOG_EN
    fr_done   = 1'b0;
    enemy_row = 3'd3;
    expect_seq(1'b0, 1'b0, 1'b0);
    wait_req();
    repeat (3) @(negedge clk);
    check("wdog_render_entered", frame_req, 1'b1);
    check("wdog_fault_before", fault, 1'b0);
    repeat (3) @(negedge clk);
    check("wdog_render_last", frame_req, 1'b1);
    @(negedge clk);
    check("wdog_idle", busy, 1'b0);
    check("wdog_fault", fault, 1'b1);
    fr_done = 1'b1;
`else
    check("fault_tied_low", fault, 1'b0);
`endif

    co_done   = 1'b0;
    enemy_row = 3'd6;
    wait_req();
    repeat (2) @(negedge clk);
    check("collide_held", collide_req, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_reqs", reqs, 4'b0000);
    check("midrst_busy", busy, 1'b0);
    check("midrst_dir", enemy_step_dir, 1'b0);
    check("midrst_hit", hit, 1'b0);
    check("midrst_score", score, 8'd0);
    check("midrst_tick_cnt", tick_cnt, 16'd0);
    check("midrst_overrun", overrun, 1'b0);
    check("midrst_fault", fault, 1'b0);
    @(negedge clk);
    rst       = 1'b1;
    co_done   = 1'b1;
    exp_tick  = '0;
    exp_score = 0;
    run_seq(3'd3, 1'b1, 1'b0, 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    check("dir_queue_drained", dir_exp_q.size(), 0);
    check("tick_queue_drained", tick_exp_q.size(), 0);
    check("score_queue_drained", score_exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin : global_timeout
    #500000;
    $display("FAIL global_timeout: reached cycle %0d, expected completion well before", cyc);
    $fatal(1, "simulation time limit");
  end

endmodule
